sync_reg_arbiter: RTL and testbench

Shares the sync block's configuration register bank between two requesters: port A (host/CPU bus bridge) and port B (internal sync sequencer). The block arbitrates round-robin and decodes the granted address into a one-hot write-enable per bank register. It drives the common write data, muxes read-back data, and returns a single-cycle acknowledge. It sits between the bus bridge or sequencer and the array of single-write, dual-read config registers.

---
 rtl/sync_regarb_pkg.sv | 20 ++
 rtl/sync_rr_arb2.sv | 43 ++++
 rtl/sync_reg_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sync_reg_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_regarb_pkg.sv
// Shared definitions for the sync config-register arbiter.
//   - FSM state encoding (IDLE, ACCESS, ACK)
//   - requester port ids (PORT_A = host bridge, PORT_B = sync sequencer)
//   - default widths, consistent with the sync block's register bank
package sync_regarb_pkg;

    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned AW_DEF   = 3;
    localparam int unsigned NREG_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sync_rr_arb2.sv
// Two-input round-robin grant for shared sync resources.
//   clk, rst_n      : clock, async active-low reset
//   req_a, req_b    : pending requests
//   upd, upd_port   : strobe recording upd_port as the last-served port
//   gnt_valid_c     : some request is pending (combinational)
//   gnt_port_c      : port to grant now (combinational)
module sync_rr_arb2
    import sync_regarb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    input  logic upd_port,
    output logic gnt_valid_c,
    output logic gnt_port_c
);

    logic rr_last;

    // Last-served port; reset to B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= PORT_B;
        end else if (upd) begin
            rr_last <= upd_port;
        end
    end

    // A lone request wins outright; on a tie the port not served last wins.
    always_comb begin
        gnt_valid_c = req_a | req_b;
        if (req_a && req_b) begin
            gnt_port_c = ~rr_last;
        end else if (req_a) begin
            gnt_port_c = PORT_A;
        end else begin
            gnt_port_c = PORT_B;
        end
    end

endmodule

// File: rtl/sync_reg_arbiter.sv
// Arbitrates the sync config register bank between port A (host bridge)
// and port B (sync sequencer). One transaction per IDLE->ACCESS->ACK pass.
//   clk, rst_n              : clock, async active-low reset
//   a_/b_ req, we, addr     : request, write/read, register address
//   a_/b_ wdata             : write data
//   a_/b_ ack, rdata        : one-cycle completion pulse, read data
//   reg_we, reg_wdata       : one-hot bank write enable, broadcast data
//   reg_rdata               : flattened bank contents, reg i at [i*DW +: DW]
//   busy                    : FSM outside IDLE
// Optional (macro SYNC_REGARB_ERR_EN): a_err/b_err pulse with ack on an
// out-of-range address, err_sticky holds until reset.
module sync_reg_arbiter
    import sync_regarb_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [AW-1:0]      a_addr,
    input  logic [DW-1:0]      a_wdata,
    output logic               a_ack,
    output logic [DW-1:0]      a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [AW-1:0]      b_addr,
    input  logic [DW-1:0]      b_wdata,
    output logic               b_ack,
    output logic [DW-1:0]      b_rdata,
    output logic [NREG-1:0]    reg_we,
    output logic [DW-1:0]      reg_wdata,
    input  logic [NREG*DW-1:0] reg_rdata,
    output logic               busy
`ifdef SYNC_REGARB_ERR_EN
    ,
    output logic               a_err,
    output logic               b_err,
    output logic               err_sticky
`endif
);

    state_t          state, state_nxt;
    logic            gnt_valid_c, gnt_port_c;
    logic            load, rr_upd;
    logic            lat_port, lat_we;
    logic [AW-1:0]   lat_addr;
    logic            sel_we, sel_oor;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW-1:0]   rd_sel;
    logic [NREG-1:0] reg_we_nxt;
    logic            a_ack_nxt, b_ack_nxt;
    logic [DW-1:0]   a_rdata_nxt, b_rdata_nxt;

    sync_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a       (a_req),
        .req_b       (b_req),
        .upd         (rr_upd),
        .upd_port    (lat_port),
        .gnt_valid_c (gnt_valid_c),
        .gnt_port_c  (gnt_port_c)
    );

    // Fields of the port being granted this cycle.
    assign sel_we    = (gnt_port_c == PORT_A) ? a_we    : b_we;
    assign sel_addr  = (gnt_port_c == PORT_A) ? a_addr  : b_addr;
    assign sel_wdata = (gnt_port_c == PORT_A) ? a_wdata : b_wdata;
    assign sel_oor   = (32'(sel_addr) >= NREG);

    // Read-back mux; an address with no bank register reads as zero.
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (lat_addr == AW'(i)) begin
                rd_sel = reg_rdata[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        rr_upd      = 1'b0;
        reg_we_nxt  = '0;
        a_ack_nxt   = 1'b0;
        b_ack_nxt   = 1'b0;
        a_rdata_nxt = a_rdata;
        b_rdata_nxt = b_rdata;
        case (state)
            IDLE: begin
                if (gnt_valid_c) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                    if (sel_we && !sel_oor) begin
                        reg_we_nxt = NREG'(1) << sel_addr;
                    end
                end
            end
            ACCESS: begin
                rr_upd    = 1'b1;
                state_nxt = ACK;
                if (lat_port == PORT_A) begin
                    a_ack_nxt = 1'b1;
                    if (!lat_we) a_rdata_nxt = rd_sel;
                end else begin
                    b_ack_nxt = 1'b1;
                    if (!lat_we) b_rdata_nxt = rd_sel;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_port  <= PORT_A;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_nxt;
            reg_we  <= reg_we_nxt;
            a_ack   <= a_ack_nxt;
            b_ack   <= b_ack_nxt;
            a_rdata <= a_rdata_nxt;
            b_rdata <= b_rdata_nxt;
            busy    <= (state_nxt != IDLE);
            if (load) begin
                lat_port  <= gnt_port_c;
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                reg_wdata <= sel_wdata;
            end
        end
    end

`ifdef SYNC_REGARB_ERR_EN
    logic lat_oor;
    assign lat_oor = (32'(lat_addr) >= NREG);

    // Error pulses line up with ack; sticky flag survives until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_err      <= 1'b0;
            b_err      <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            a_err <= (state == ACCESS) && lat_oor && (lat_port == PORT_A);
            b_err <= (state == ACCESS) && lat_oor && (lat_port == PORT_B);
            if ((state == ACCESS) && lat_oor) err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_reg_arbiter.sv
// Scoreboard bench for sync_reg_arbiter (DW=16, NREG=8, AW=4).
module tb_sync_reg_arbiter;

    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 4;

    typedef struct {
        logic        port;
        int          cyc;
        logic [15:0] ard;
        logic [15:0] brd;
        logic        err;
    } ack_exp_t;

    typedef struct {
        logic [7:0]  we;
        logic [15:0] wd;
        int          cyc;
    } we_exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0]      a_addr = '0;
    logic [DW-1:0]      a_wdata = '0;
    logic               a_ack;
    logic [DW-1:0]      a_rdata;
    logic               b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0]      b_addr = '0;
    logic [DW-1:0]      b_wdata = '0;
    logic               b_ack;
    logic [DW-1:0]      b_rdata;
    logic [NREG-1:0]    reg_we;
    logic [DW-1:0]      reg_wdata;
    logic [NREG*DW-1:0] reg_rdata;
    logic               busy;
`ifdef SYNC_REGARB_ERR_EN
    logic               a_err, b_err, err_sticky;
`endif

    logic [DW-1:0] bank [NREG];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    ack_exp_t      aq[$];
    we_exp_t       wq[$];
    ack_exp_t      mon_a;
    we_exp_t       mon_w;
    logic          auto_drop = 1'b1;

    sync_reg_arbiter #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_ack      (a_ack),
        .a_rdata    (a_rdata),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_ack      (b_ack),
        .b_rdata    (b_rdata),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
`ifdef SYNC_REGARB_ERR_EN
        ,
        .a_err      (a_err),
        .b_err      (b_err),
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: preloaded once, then written by reg_we.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (cyc == 0) bank[i] <= 16'h1000 + 16'(i);
            else if (reg_we[i]) bank[i] <= reg_wdata;
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NREG; i++) reg_rdata[i*DW +: DW] = bank[i];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows a write or an ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we != '0) begin
                if (wq.size() == 0) begin
                    check("unexpected_reg_we", 32'(reg_we), 32'h0);
                end else begin
                    mon_w = wq.pop_front();
                    check("reg_we_onehot", 32'(reg_we), 32'(mon_w.we));
                    check("reg_wdata", 32'(reg_wdata), 32'(mon_w.wd));
                    check("reg_we_cycle", 32'(cyc), 32'(mon_w.cyc));
                end
            end
            if (a_ack || b_ack) begin
                if (aq.size() == 0) begin
                    check("unexpected_ack", {30'h0, b_ack, a_ack}, 32'h0);
                end else begin
                    mon_a = aq.pop_front();
                    check("ack_both", 32'(a_ack & b_ack), 32'h0);
                    check("ack_port", 32'(b_ack), 32'(mon_a.port));
                    check("ack_cycle", 32'(cyc), 32'(mon_a.cyc));
                    check("a_rdata", 32'(a_rdata), 32'(mon_a.ard));
                    check("b_rdata", 32'(b_rdata), 32'(mon_a.brd));
`ifdef SYNC_REGARB_ERR_EN
                    check("a_err", 32'(a_err), 32'(mon_a.err & ~mon_a.port));
                    check("b_err", 32'(b_err), 32'(mon_a.err & mon_a.port));
`endif
                end
            end
        end
    end

    task automatic issue(input logic port, input logic we, input logic [3:0] addr,
                         input logic [15:0] wd);
        if (port == 1'b0) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end
    endtask

    task automatic push_we(input logic [7:0] oh, input logic [15:0] wd, input int c);
        we_exp_t e;
        e.we = oh; e.wd = wd; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic push_ack(input logic port, input int c, input logic [15:0] ard,
                            input logic [15:0] brd, input logic err);
        ack_exp_t e;
        e.port = port; e.cyc = c; e.ard = ard; e.brd = brd; e.err = err;
        aq.push_back(e);
    endtask

    // Requesters drop req on seeing ack; returns once all expectations are met.
    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (auto_drop) begin
                if (a_ack) a_req = 1'b0;
                if (b_ack) b_req = 1'b0;
            end
            if (aq.size() == 0 && wq.size() == 0 && !busy && !a_req && !b_req) break;
            n++;
            if (n > 60) begin
                check("drain_timeout", 32'(aq.size() + wq.size()), 32'h0);
                aq.delete(); wq.delete();
                a_req = 1'b0; b_req = 1'b0;
                break;
            end
        end
    endtask

    // Single-port transaction from an idle arbiter.
    task automatic one(input logic port, input logic we, input logic [3:0] addr,
                       input logic [15:0] wd, input logic [7:0] oh,
                       input logic [15:0] ard, input logic [15:0] brd, input logic err);
        int c;
        c = cyc;
        issue(port, we, addr, wd);
        if (we && oh != 8'h0) push_we(oh, wd, c + 1);
        push_ack(port, c + 2, ard, brd, err);
        drain();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int c;
        do_reset();

        // Reset values
        check("rst_a_ack", 32'(a_ack), 32'h0);
        check("rst_b_ack", 32'(b_ack), 32'h0);
        check("rst_a_rdata", 32'(a_rdata), 32'h0);
        check("rst_b_rdata", 32'(b_rdata), 32'h0);
        check("rst_reg_we", 32'(reg_we), 32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef SYNC_REGARB_ERR_EN
        check("rst_err_sticky", 32'(err_sticky), 32'h0);
`endif

        // 1: A writes 0x1234 to reg 2
        one(1'b0, 1'b1, 4'd2, 16'h1234, 8'h04, 16'h0, 16'h0, 1'b0);

        // 2: tie from reset -> A then B; then A alone; tie again -> B first
        do_reset();
        c = cyc;
        issue(1'b0, 1'b1, 4'd0, 16'hAAAA);
        issue(1'b1, 1'b1, 4'd1, 16'h5555);
        push_we(8'h01, 16'hAAAA, c + 1); push_ack(1'b0, c + 2, 16'h0, 16'h0, 1'b0);
        push_we(8'h02, 16'h5555, c + 4); push_ack(1'b1, c + 5, 16'h0, 16'h0, 1'b0);
        drain();
        one(1'b0, 1'b1, 4'd4, 16'h4444, 8'h10, 16'h0, 16'h0, 1'b0);
        c = cyc;
        issue(1'b0, 1'b1, 4'd6, 16'h6666);
        issue(1'b1, 1'b1, 4'd7, 16'h7777);
        push_we(8'h80, 16'h7777, c + 1); push_ack(1'b1, c + 2, 16'h0, 16'h0, 1'b0);
        push_we(8'h40, 16'h6666, c + 4); push_ack(1'b0, c + 5, 16'h0, 16'h0, 1'b0);
        drain();

        // 3: B writes 0xBEEF to reg 5, A reads it back; more reads
        one(1'b1, 1'b1, 4'd5, 16'hBEEF, 8'h20, 16'h0, 16'h0, 1'b0);
        one(1'b0, 1'b0, 4'd5, 16'h0, 8'h0, 16'hBEEF, 16'h0, 1'b0);
        one(1'b1, 1'b0, 4'd2, 16'h0, 8'h0, 16'hBEEF, 16'h1234, 1'b0);
        one(1'b0, 1'b0, 4'd0, 16'h0, 8'h0, 16'hAAAA, 16'h1234, 1'b0);

        // 4: out-of-range write and read at address 9
        one(1'b0, 1'b1, 4'd9, 16'h9999, 8'h0, 16'hAAAA, 16'h1234, 1'b1);
        one(1'b0, 1'b0, 4'd9, 16'h0, 8'h0, 16'h0, 16'h1234, 1'b1);
`ifdef SYNC_REGARB_ERR_EN
        check("err_sticky_set", 32'(err_sticky), 32'h1);
`endif

        // 5: reset during ACCESS of a write to reg 3
        issue(1'b0, 1'b1, 4'd3, 16'h7777);
        @(posedge clk); #1;
        check("t5_we_live", 32'(reg_we), 32'h08);
        #1 rst_n = 1'b0;
        #1;
        check("t5_we_dropped", 32'(reg_we), 32'h0);
        check("t5_busy_rst", 32'(busy), 32'h0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t5_busy_after", 32'(busy), 32'h0);
        check("t5_bank3_kept", 32'(bank[3]), 32'h1003);
`ifdef SYNC_REGARB_ERR_EN
        check("t5_err_sticky_clr", 32'(err_sticky), 32'h0);
`endif
        one(1'b0, 1'b0, 4'd3, 16'h0, 8'h0, 16'h1003, 16'h0, 1'b0);

        // 6: A holds req with B idle -> one transaction every 3 cycles
        auto_drop = 1'b0;
        c = cyc;
        issue(1'b0, 1'b1, 4'd3, 16'h0606);
        for (int k = 0; k < 3; k++) begin
            push_we(8'h08, 16'h0606, c + 1 + 3 * k);
            push_ack(1'b0, c + 2 + 3 * k, 16'h1003, 16'h0, 1'b0);
        end
        repeat (9) begin @(posedge clk); #1; end
        a_req = 1'b0;
        drain();
        auto_drop = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t6_bank3", 32'(bank[3]), 32'h0606);
        check("t6_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
